// File: rtl/stream_rank_sorter.sv
// rtl/stream_rank_sorter.sv - serial frame sorter: load N words, rank one per cycle, emit in order
// Stable ascending/descending compare-count ranking with valid/ready on both sides.
module stream_rank_sorter #(
    parameter int N     = 6,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   descending,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(N)-1:0]   out_index,
    output logic                   out_last,
    output logic                   busy
);

    localparam int IDXW = $clog2(N);
    localparam logic [IDXW-1:0] CNT_LAST = IDXW'(N - 1);
    localparam logic [IDXW-1:0] CNT_ONE  = IDXW'(1);
    localparam logic [IDXW:0]   SUM_ONE  = (IDXW + 1)'(1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_RANK,
        S_EMIT
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [IDXW-1:0]  r_cnt;
    logic             r_mode;
    logic [WIDTH-1:0] r_buf    [N];
    logic [WIDTH-1:0] r_sorted [N];
    logic [IDXW-1:0]  r_sidx   [N];

    logic             r_out_valid;
    logic             r_out_last;
    logic [WIDTH-1:0] r_out_data;
    logic [IDXW-1:0]  r_out_index;

    logic             w_cnt_last;
    logic [IDXW-1:0]  w_cnt_next;
    logic             w_load_fire;
    logic             w_rank_step;
    logic             w_emit_prime;
    logic             w_emit_fire;
    logic [WIDTH-1:0] w_cur;
    logic [IDXW:0]    w_rank_sum;
    logic [IDXW-1:0]  w_rank;

    assign w_cnt_last   = (r_cnt == CNT_LAST);
    assign w_cnt_next   = r_cnt + CNT_ONE;
    assign in_ready     = (r_state == S_LOAD);
    assign busy         = (r_state != S_LOAD);
    assign w_load_fire  = in_ready && in_valid && !flush;
    assign w_rank_step  = (r_state == S_RANK) && !flush;
    assign w_emit_prime = (r_state == S_EMIT) && !r_out_valid && !flush;
    assign w_emit_fire  = (r_state == S_EMIT) && r_out_valid && out_ready && !flush;

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_out_data;
    assign out_index = r_out_index;

    // Strictly-better keys plus earlier equal keys: ties keep arrival order in both modes.
    always_comb begin
        w_cur      = r_buf[r_cnt];
        w_rank_sum = '0;
        for (int j = 0; j < N; j++) begin
            if (r_mode ? (r_buf[j] > w_cur) : (r_buf[j] < w_cur)) begin
                w_rank_sum = w_rank_sum + SUM_ONE;
            end else if ((r_buf[j] == w_cur) && (IDXW'(j) < r_cnt)) begin
                w_rank_sum = w_rank_sum + SUM_ONE;
            end
        end
        w_rank = w_rank_sum[IDXW-1:0];
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LOAD:  if (w_load_fire && w_cnt_last) w_state_next = S_RANK;
            S_RANK:  if (w_cnt_last) w_state_next = S_EMIT;
            S_EMIT:  if (w_emit_fire && r_out_last) w_state_next = S_LOAD;
            default: w_state_next = S_LOAD;
        endcase
        if (flush) begin
            w_state_next = S_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_mode      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
        end else if (flush) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_load_fire) begin
                r_cnt <= w_cnt_last ? '0 : w_cnt_next;
                if (r_cnt == '0) begin
                    r_mode <= descending;
                end
            end
            if (w_rank_step) begin
                r_cnt <= w_cnt_last ? '0 : w_cnt_next;
            end
            // First EMIT cycle only loads the output register from slot 0.
            if (w_emit_prime) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_sorted[0];
                r_out_index <= r_sidx[0];
                r_out_last  <= 1'b0;
            end
            if (w_emit_fire) begin
                if (r_out_last) begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_cnt       <= '0;
                end else begin
                    r_cnt       <= w_cnt_next;
                    r_out_data  <= r_sorted[w_cnt_next];
                    r_out_index <= r_sidx[w_cnt_next];
                    r_out_last  <= (w_cnt_next == CNT_LAST);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load_fire) begin
            r_buf[r_cnt] <= in_data;
        end
        if (w_rank_step) begin
            r_sorted[w_rank] <= w_cur;
            r_sidx[w_rank]   <= r_cnt;
        end
    end

endmodule

// File: tb/tb_stream_rank_sorter.sv
// tb/tb_stream_rank_sorter.sv - scoreboard bench for stream_rank_sorter
module tb_stream_rank_sorter;

    localparam int N     = 6;
    localparam int WIDTH = 8;
    localparam int IDXW  = $clog2(N);

    typedef logic [WIDTH-1:0] frame_t [N];
    typedef struct {
        logic [WIDTH-1:0] d;
        logic [IDXW-1:0]  idx;
        logic             last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             descending = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [IDXW-1:0]  out_index;
    logic             out_last;
    logic             busy;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    exp_t sb[$];

    stream_rank_sorter #(.N(N), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .descending(descending),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: repeated selection of the best remaining key, earliest index wins ties.
    task automatic push_expected(input frame_t w, input logic desc);
        bit   used [N];
        int   best;
        exp_t e;
        for (int j = 0; j < N; j++) used[j] = 1'b0;
        for (int k = 0; k < N; k++) begin
            best = -1;
            for (int j = 0; j < N; j++) begin
                if (!used[j]) begin
                    if (best < 0) best = j;
                    else if (desc ? (w[j] > w[best]) : (w[j] < w[best])) best = j;
                end
            end
            used[best] = 1'b1;
            e.d    = w[best];
            e.idx  = IDXW'(best);
            e.last = (k == N - 1);
            sb.push_back(e);
        end
    endtask

    task automatic send_frame(input frame_t w, input logic desc, input bit toggle,
                              input bit gaps, input bit push);
        int t;
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    in_valid = 1'b0;
                    tick();
                end
            end
            in_valid   = 1'b1;
            in_data    = w[i];
            descending = (i == 0) ? desc : (toggle ? ~desc : desc);
            t = 0;
            while (in_ready !== 1'b1 && t < 100) begin
                tick();
                t++;
            end
            if (t >= 100) begin
                checks++;
                failures++;
                $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
            end
            tick();
        end
        in_valid   = 1'b0;
        accept_cyc = cyc;
        if (push) push_expected(w, desc);
    endtask

    task automatic collect(input bit bp, input int max_beats, input bit check_lat);
        int               t;
        int               n;
        bit               done;
        bit               seen;
        logic             pv;
        logic             pr;
        logic [WIDTH-1:0] pd;
        logic [IDXW-1:0]  pi;
        logic             pl;
        exp_t             e;
        t = 0; n = 0; done = 0; seen = 0; pv = 0; pr = 0; pd = '0; pi = '0; pl = 0;
        while (!done && t < 2000) begin
            if (pv && !pr) begin
                checks++;
                if ({out_valid, out_data, out_index, out_last} !== {pv, pd, pi, pl}) begin
                    failures++;
                    $display("FAIL stall_hold: got v=%b d=%0d i=%0d l=%b required v=%b d=%0d i=%0d l=%b",
                             out_valid, out_data, out_index, out_last, pv, pd, pi, pl);
                end
            end
            if (busy === 1'b1) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL in_ready_while_busy: in_ready=%b required 0", in_ready);
                end
            end
            if (out_valid === 1'b1 && !seen) begin
                seen = 1;
                if (check_lat) begin
                    checks++;
                    if (cyc - accept_cyc != N + 1) begin
                        failures++;
                        $display("FAIL latency: got %0d cycles required %0d", cyc - accept_cyc, N + 1);
                    end
                end
            end
            out_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat: got data=%0d idx=%0d required no output", out_data, out_index);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.d || out_index !== e.idx || out_last !== e.last) begin
                        failures++;
                        $display("FAIL beat_%0d: got data=%0d idx=%0d last=%b required data=%0d idx=%0d last=%b",
                                 n, out_data, out_index, out_last, e.d, e.idx, e.last);
                    end
                end
                n++;
                if (out_last === 1'b1 || n == max_beats) done = 1;
            end
            pv = out_valid; pr = out_ready; pd = out_data; pi = out_index; pl = out_last;
            tick();
            t++;
        end
        out_ready = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL collect_timeout: got %0d beats required %0d", n, max_beats);
        end else if (n == N && (out_valid !== 1'b0 || in_ready !== 1'b1)) begin
            failures++;
            $display("FAIL frame_end: got out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({in_ready, out_valid, out_data, out_index, out_last, busy} !==
            {1'b1, 1'b0, {WIDTH{1'b0}}, {IDXW{1'b0}}, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL %s: got rdy=%b v=%b d=%0d i=%0d l=%b busy=%b required 1 0 0 0 0 0",
                     name, in_ready, out_valid, out_data, out_index, out_last, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        tick();
        check_reset_outputs("after_reset_release");
    endtask

    task automatic test_ascending();
        frame_t f;
        f = '{5, 3, 8, 3, 1, 9};
        send_frame(f, 1'b0, 1'b0, 1'b0, 1'b1);
        collect(1'b0, N, 1'b1);
    endtask

    task automatic test_descending_toggle();
        frame_t f;
        f = '{5, 3, 8, 3, 1, 9};
        send_frame(f, 1'b1, 1'b1, 1'b0, 1'b1);
        collect(1'b0, N, 1'b1);
    endtask

    task automatic test_duplicates_extremes();
        frame_t f;
        f = '{7, 7, 7, 7, 7, 7};
        send_frame(f, 1'b0, 1'b0, 1'b0, 1'b1);
        collect(1'b0, N, 1'b0);
        send_frame(f, 1'b1, 1'b0, 1'b0, 1'b1);
        collect(1'b0, N, 1'b0);
        f = '{255, 0, 255, 0, 128, 0};
        send_frame(f, 1'b0, 1'b0, 1'b0, 1'b1);
        collect(1'b0, N, 1'b0);
        send_frame(f, 1'b1, 1'b0, 1'b0, 1'b1);
        collect(1'b0, N, 1'b0);
    endtask

    task automatic test_random_backpressure();
        frame_t f;
        logic   d;
        for (int fr = 0; fr < 20; fr++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) f[i] = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
                else f[i] = WIDTH'($urandom_range(0, 15));
            end
            d = ($urandom_range(0, 1) == 1);
            send_frame(f, d, ($urandom_range(0, 1) == 1), 1'b1, 1'b1);
            collect(1'b1, N, 1'b0);
        end
    endtask

    task automatic test_flush();
        frame_t f;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(40 + i);
            tick();
        end
        in_data = 8'd99;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_load: got rdy=%b busy=%b v=%b required 1 0 0", in_ready, busy, out_valid);
        end
        f = '{6, 5, 4, 3, 2, 1};
        send_frame(f, 1'b0, 1'b0, 1'b0, 1'b1);
        collect(1'b0, N, 1'b0);

        f = '{10, 20, 30, 40, 50, 60};
        send_frame(f, 1'b0, 1'b0, 1'b0, 1'b1);
        collect(1'b0, 2, 1'b0);
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_emit: got v=%b l=%b rdy=%b busy=%b required 0 0 1 0",
                     out_valid, out_last, in_ready, busy);
        end
        sb.delete();
        f = '{3, 9, 1, 9, 0, 2};
        send_frame(f, 1'b1, 1'b0, 1'b0, 1'b1);
        collect(1'b0, N, 1'b1);
    endtask

    task automatic test_reset_mid_rank();
        frame_t f;
        f = '{11, 22, 33, 44, 55, 66};
        send_frame(f, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_rank");
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        f = '{200, 17, 0, 255, 17, 90};
        send_frame(f, 1'b0, 1'b0, 1'b0, 1'b1);
        collect(1'b0, N, 1'b1);
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_descending_toggle();
        test_duplicates_extremes();
        test_random_backpressure();
        test_flush();
        test_reset_mid_rank();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_rank_sorter.md
Name: stream_rank_sorter

Overview:
- Parametrised successor to the team's single-shot rank sorter.
- Accepts a frame of N unsigned words serially over a valid/ready input stream and ranks them one element per cycle using a compare-count network.
- Emits the sorted frame serially over a valid/ready output stream, tagging each word with its original arrival index.
- Adds over the previous generation: ascending/descending mode, stable ordering of duplicates, back-pressure on both sides, and a synchronous flush.

Parameters:
- N, 6, elements per frame (N >= 2).
- WIDTH, 8, bits per element (unsigned compare).
- IDXW, $clog2(N), width of index and counters (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; drops current frame.
- descending  input  1  sort order; sampled on first accepted word of a frame.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  input word.
- out_valid  output  1  sorted word valid.
- out_ready  input  1  consumer accepts word.
- out_data  output  WIDTH  sorted word.
- out_index  output  IDXW  arrival index (0..N-1) of out_data.
- out_last  output  1  high with the final word of the frame.
- busy  output  1  high in RANK or EMIT.

Behaviour:
- Reset (rst_n=0, async): state=LOAD, counters=0, in_ready=1, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0. Data buffers are not reset.
- States: LOAD -> RANK -> EMIT -> LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: buf[cnt]<=in_data, cnt++.
  - The word with cnt==0 also latches mode<=descending.
  - The Nth accepted word moves to RANK, cnt<=0.
  - in_ready is never asserted outside LOAD.
- RANK:
  - One element i per cycle, i=0..N-1.
  - Ascending rank(i) = #{j : buf[j] < buf[i]} + #{j < i : buf[j] == buf[i]}.
  - Descending: same, with > in place of <.
  - Write sorted[rank]<=buf[i] and sidx[rank]<=i.
  - Ranks form a permutation of 0..N-1 by construction; no collision handling is needed.
  - After i=N-1, go to EMIT. RANK lasts exactly N cycles.
- EMIT:
  - out_valid=1; out_data=sorted[k], out_index=sidx[k], out_last=(k==N-1). All outputs are registered.
  - On out_valid&out_ready: k++.
  - Handshake with out_last returns to LOAD, out_valid=0 next cycle.
  - While out_ready=0, outputs hold stable.
- Latency: first out_valid occurs N+1 cycles after the cycle accepting the Nth input (N RANK cycles plus 1 register).
  - Minimum frame period is 3N+1 cycles with no back-pressure.
- flush=1 (any state, priority over handshakes):
  - Next cycle: LOAD, cnt=i=k=0, out_valid=0, out_last=0.
  - A handshake coincident with flush is discarded.
- Reset mid-frame behaves as flush, asynchronously.
- in_valid while not in LOAD is ignored; no data loss is attributed to the block.
- Boundary values: equal keys keep arrival order in both modes. 0 and 2^WIDTH-1 compare correctly as unsigned.
- The descending pin may change during RANK/EMIT without effect. Only the latched mode is used.

Test Plan:
1. N=6, W=8, asc, inputs 5,3,8,3,1,9, out_ready=1 -> out_data 1,3,3,5,8,9; out_index 4,1,3,0,2,5; out_last only on 9; first out_valid 7 cycles after the 6th input.
2. Same inputs, descending=1 on first word then toggled to 0 mid-frame -> 9,8,5,3,3,1; indices 5,2,0,1,3,4.
3. All inputs 7 in both modes -> data 7 x6, indices 0,1,2,3,4,5 (stability); inputs 255,0,255,0,128,0 asc -> 0,0,0,128,255,255, indices 1,3,5,4,0,2.
4. Random out_ready back-pressure (~50%) and gapped in_valid over 20 random frames -> output matches a stable reference sort; outputs stable while stalled; in_ready=0 throughout RANK/EMIT.
5. flush after 3 inputs, then a full new frame 6,5,4,3,2,1 -> only 1..6 emitted, indices 5..0; flush during EMIT after 2 beats -> out_valid drops next cycle, in_ready=1.
6. rst_n pulsed low mid-RANK -> all outputs at reset values immediately; next frame sorts correctly.
